// File: rtl/div_ctrl_if.sv
// Request/writeback and divider-side signals of the divide sequencer.
// Signal names carry their direction as seen from div_ctrl.
interface div_ctrl_if;
   logic        req_valid_i;
   logic [1:0]  op_i;
   logic [31:0] rs1_i;
   logic [31:0] rs2_i;
   logic [4:0]  rd_i;
   logic        flush_i;
   logic        stall_o;
   logic        wb_valid_o;
   logic [4:0]  wb_rd_o;
   logic [31:0] wb_data_o;
   logic        err_o;
   logic        div_start_o;
   logic        div_annul_o;
   logic        div_signed_o;
   logic [31:0] div_dividend_o;
   logic [31:0] div_divisor_o;
   logic [63:0] div_result_i;
   logic        div_ready_i;

   modport slave (
      input  req_valid_i, op_i, rs1_i, rs2_i, rd_i, flush_i, div_result_i, div_ready_i,
      output stall_o, wb_valid_o, wb_rd_o, wb_data_o, err_o,
      output div_start_o, div_annul_o, div_signed_o, div_dividend_o, div_divisor_o
   );

   modport master (
      output req_valid_i, op_i, rs1_i, rs2_i, rd_i, flush_i, div_result_i, div_ready_i,
      input  stall_o, wb_valid_o, wb_rd_o, wb_data_o, err_o,
      input  div_start_o, div_annul_o, div_signed_o, div_dividend_o, div_divisor_o
   );
endinterface

// File: rtl/div_ctrl.sv
// Divide sequencer: decodes DIV/DIVU/REM/REMU, short-cuts RISC-V special cases and repeated
// operands, otherwise runs the iterative divider under a watchdog.
module div_ctrl #(
   parameter bit          CACHE_EN       = 1'b1,
   parameter int unsigned TIMEOUT_CYCLES = 48
) (
   input logic        clk_i,
   input logic        n_rst_i,
   div_ctrl_if.slave  bus
);
   localparam int unsigned WdogW    = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [WdogW-1:0] WdogLast = WdogW'(TIMEOUT_CYCLES - 1);

   typedef enum logic [1:0] {StIdle, StRun, StDone, StAbort} state_e;

   state_e           r_state, w_state_d;
   logic             r_signed, r_rem;
   logic [31:0]      r_rs1, r_rs2;
   logic [4:0]       r_rd;
   logic [63:0]      r_result;
   logic [WdogW-1:0] r_wdog;
   logic             r_cache_valid, r_cache_signed;
   logic [31:0]      r_cache_rs1, r_cache_rs2;
   logic [63:0]      r_cache_result;

   logic        w_accept, w_capture, w_signed_in, w_div0, w_ovf, w_hit;
   logic [63:0] w_fast_result;

   assign w_signed_in = ~bus.op_i[0];
   assign w_div0      = (bus.rs2_i == 32'h0);
   assign w_ovf       = w_signed_in & (bus.rs1_i == 32'h8000_0000) & (bus.rs2_i == 32'hFFFF_FFFF);
   assign w_hit       = CACHE_EN & r_cache_valid & (r_cache_signed == w_signed_in) &
                        (r_cache_rs1 == bus.rs1_i) & (r_cache_rs2 == bus.rs2_i);
   assign w_fast_result = w_div0 ? {bus.rs1_i, 32'hFFFF_FFFF} :
                          w_ovf  ? {32'h0, 32'h8000_0000} : r_cache_result;

   assign bus.stall_o        = bus.req_valid_i & (r_state != StDone);
   assign bus.div_signed_o   = r_signed;
   assign bus.div_dividend_o = r_rs1;
   assign bus.div_divisor_o  = r_rs2;

   always_comb begin
      w_state_d       = r_state;
      w_accept        = 1'b0;
      w_capture       = 1'b0;
      bus.wb_valid_o  = 1'b0;
      bus.wb_rd_o     = 5'h0;
      bus.wb_data_o   = 32'h0;
      bus.err_o       = 1'b0;
      bus.div_start_o = 1'b0;
      bus.div_annul_o = 1'b0;
      unique case (r_state)
         StIdle: begin
            if (bus.req_valid_i && !bus.flush_i) begin
               w_accept  = 1'b1;
               w_state_d = (w_div0 || w_ovf || w_hit) ? StDone : StRun;
            end
         end
         StRun: begin
            bus.div_start_o = 1'b1;
            // Flush beats a simultaneous ready; a ready on the last watchdog cycle still counts.
            if (bus.flush_i) begin
               w_state_d = StAbort;
            end else if (bus.div_ready_i) begin
               w_capture = 1'b1;
               w_state_d = StDone;
            end else if (r_wdog == WdogLast) begin
               bus.err_o = 1'b1;
               w_state_d = StAbort;
            end
         end
         StDone: begin
            bus.wb_valid_o = ~bus.flush_i;
            bus.wb_rd_o    = r_rd;
            bus.wb_data_o  = r_rem ? r_result[63:32] : r_result[31:0];
            w_state_d      = StIdle;
         end
         StAbort: begin
            bus.div_annul_o = 1'b1;
            w_state_d       = StIdle;
         end
         default: w_state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk_i or negedge n_rst_i) begin
      if (!n_rst_i) begin
         r_state        <= StIdle;
         r_signed       <= 1'b0;
         r_rem          <= 1'b0;
         r_rs1          <= 32'h0;
         r_rs2          <= 32'h0;
         r_rd           <= 5'h0;
         r_result       <= 64'h0;
         r_wdog         <= '0;
         r_cache_valid  <= 1'b0;
         r_cache_signed <= 1'b0;
         r_cache_rs1    <= 32'h0;
         r_cache_rs2    <= 32'h0;
         r_cache_result <= 64'h0;
      end else begin
         r_state <= w_state_d;
         if (w_accept) begin
            r_signed <= w_signed_in;
            r_rem    <= bus.op_i[1];
            r_rs1    <= bus.rs1_i;
            r_rs2    <= bus.rs2_i;
            r_rd     <= bus.rd_i;
            r_result <= w_fast_result;
            r_wdog   <= '0;
         end else if (r_state == StRun) begin
            r_wdog <= r_wdog + WdogW'(1);
         end
         if (w_capture) begin
            r_result <= bus.div_result_i;
            if (CACHE_EN) begin
               r_cache_valid  <= 1'b1;
               r_cache_signed <= r_signed;
               r_cache_rs1    <= r_rs1;
               r_cache_rs2    <= r_rs2;
               r_cache_result <= bus.div_result_i;
            end
         end
      end
   end
endmodule
